// File: rtl/gate_tb_pkg.sv
// rtl/gate_tb_pkg.sv - shared state encoding and LFSR constants for the gate stimulus sequencer
package gate_tb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        RANDOM = 2'd2,
        DONE   = 2'd3
    } gate_state_e;

    localparam logic [15:0] LFSR_MASK         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

endpackage

// File: rtl/stim_lfsr16.sv
// rtl/stim_lfsr16.sv - 16-bit Galois LFSR with seed load and single-step control
module stim_lfsr16
    import gate_tb_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    output logic [15:0] next_val
);

    logic [15:0] state_q;
    logic [15:0] state_d;
    logic [15:0] step_val;

    // Galois right-shift: feed the dropped bit back through the tap mask
    always_comb begin
        step_val = state_q >> 1;
        if (state_q[0]) begin
            step_val = (state_q >> 1) ^ LFSR_MASK;
        end
        state_d = state_q;
        if (load) begin
            state_d = SEED;
        end else if (step) begin
            state_d = step_val;
        end
    end

    // State register; reload the seed on reset so every run is repeatable
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    // The caller latches the post-step value as the new vector in the same edge
    assign next_val = step_val;

endmodule

// File: rtl/gate_stim_gen.sv
// rtl/gate_stim_gen.sv - clocked exhaustive gate input sweeper; RAND_MODE_EN adds an LFSR random phase
module gate_stim_gen
    import gate_tb_pkg::*;
#(
    parameter int          N_IN       = 2,
    parameter int          HOLD       = 5,
    parameter int          LOOPS      = 2,
    parameter int          RAND_COUNT = 8,
    parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] vec,
    output logic            vec_stb,
    output logic [N_IN+3:0] vec_idx,
    output logic            busy,
    output logic            done
);

    localparam int              IW         = N_IN + 4;
    localparam logic [N_IN-1:0] VEC_MAX    = '1;
    localparam logic [7:0]      HOLD_LAST  = 8'(HOLD - 1);
    localparam logic [3:0]      LOOPS_LAST = 4'(LOOPS - 1);

    // Reject configurations the counters cannot represent
    if (N_IN < 1 || N_IN > 8 || HOLD < 1 || HOLD > 255 || LOOPS < 1 || LOOPS > 15 ||
        RAND_COUNT < 0 || LFSR_SEED == 16'h0000) begin : g_bad_params
        $error("gate_stim_gen: illegal parameter set");
    end

    gate_state_e     state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic            stb_q, stb_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      hold_q, hold_d;
    logic [3:0]      loop_q, loop_d;

`ifdef RAND_MODE_EN
    localparam logic [15:0] RAND_LAST = 16'(RAND_COUNT - 1);

    logic [15:0] rand_q, rand_d;
    logic        lfsr_load;
    logic        lfsr_step;
    logic [15:0] lfsr_next;

    stim_lfsr16 #(
        .SEED     (LFSR_SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (lfsr_load),
        .step     (lfsr_step),
        .next_val (lfsr_next)
    );
`endif

    // Next-state: hold counter paces vectors, loop counter counts full sweeps
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        stb_d   = 1'b0;
        idx_d   = idx_q;
        hold_d  = hold_q;
        loop_d  = loop_q;
`ifdef RAND_MODE_EN
        rand_d    = rand_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SWEEP;
                    vec_d   = '0;
                    stb_d   = 1'b1;
                    idx_d   = '0;
                    hold_d  = '0;
                    loop_d  = '0;
`ifdef RAND_MODE_EN
                    rand_d    = '0;
                    lfsr_load = 1'b1;
`endif
                end
            end
            SWEEP: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (vec_q == VEC_MAX && loop_q == LOOPS_LAST) begin
`ifdef RAND_MODE_EN
                        if (RAND_COUNT > 0) begin
                            state_d   = RANDOM;
                            lfsr_step = 1'b1;
                            vec_d     = lfsr_next[N_IN-1:0];
                            stb_d     = 1'b1;
                            idx_d     = idx_q + 1'b1;
                            rand_d    = '0;
                        end else begin
                            state_d = DONE;
                        end
`else
                        state_d = DONE;
`endif
                    end else begin
                        if (vec_q == VEC_MAX) begin
                            loop_d = loop_q + 1'b1;
                        end
                        vec_d = vec_q + 1'b1;
                        stb_d = 1'b1;
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
`ifdef RAND_MODE_EN
            RANDOM: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (rand_q == RAND_LAST) begin
                        state_d = DONE;
                    end else begin
                        rand_d    = rand_q + 1'b1;
                        lfsr_step = 1'b1;
                        vec_d     = lfsr_next[N_IN-1:0];
                        stb_d     = 1'b1;
                        idx_d     = idx_q + 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over any run in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            stb_q   <= 1'b0;
            idx_q   <= '0;
            hold_q  <= '0;
            loop_q  <= '0;
`ifdef RAND_MODE_EN
            rand_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            stb_q   <= stb_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            loop_q  <= loop_d;
`ifdef RAND_MODE_EN
            rand_q  <= rand_d;
`endif
        end
    end

    assign vec     = vec_q;
    assign vec_stb = stb_q;
    assign vec_idx = idx_q;
    assign busy    = (state_q == SWEEP) || (state_q == RANDOM);
    assign done    = (state_q == DONE);

endmodule
